seq_bin2bcd: RTL and testbench

SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

---
 rtl/seq_bin2bcd.sv | 152 +++++++++++++++
 tb/tb_seq_bin2bcd.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : seq_bin2bcd
// Purpose  : Sequential binary-to-BCD converter using the shift-and-add-3
//            (double dabble) method. One operand bit is processed per clock.
//            The block optionally treats the operand as two's complement and
//            reports the sign separately. It also flags results that do not
//            fit in DIGITS digits.
// Ports    : clk          - clock, rising edge active
//            rst_n        - asynchronous active-low reset
//            start        - conversion request, honoured only while ready
//            signed_mode  - 1: bin is two's complement, 0: unsigned
//            bin          - binary operand (BIN_W bits)
//            ready        - high in IDLE and DONE (start will be accepted)
//            done         - one-cycle pulse, new bcd/neg/ovf are valid
//            bcd          - packed BCD result, digit 0 in bits [3:0]
//            neg          - result sign
//            ovf          - magnitude exceeded DIGITS digits (bcd invalid)
// Revision : 1.0 - initial release
// ============================================================================
module seq_bin2bcd #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [BIN_W-1:0]   c_one_bin = {{(BIN_W-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0] c_cnt_one = {{(c_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0] c_cnt_ld  = c_cnt_w'(BIN_W);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [BIN_W-1:0]    r_mag;
    logic [c_bcd_w-1:0]  r_work;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_neg_work;
    logic                r_ovf_work;

    logic                w_accept;
    logic                w_last;
    logic                w_in_neg;
    logic [BIN_W-1:0]    w_in_mag;
    logic [c_bcd_w-1:0]  w_adj;
    logic [c_bcd_w-1:0]  w_work_nxt;
    logic                w_ovf_nxt;

    // Operand conditioning: negative signed operands are converted to their
    // magnitude. The most negative value maps onto 2^(BIN_W-1), which is
    // still representable as an unsigned BIN_W-bit value.
    assign w_in_neg = signed_mode & bin[BIN_W-1];
    assign w_in_mag = w_in_neg ? (~bin + c_one_bin) : bin;

    // Per-digit add-3 correction. Each digit is independent 4-bit arithmetic
    // and does not carry into the next digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5)
                                    ? (r_work[4*gi +: 4] + 4'd3)
                                    : r_work[4*gi +: 4];
        end
    endgenerate

    // Any 1 falling out of the top digit means the value no longer fits.
    assign w_work_nxt = {w_adj[c_bcd_w-2:0], r_mag[BIN_W-1]};
    assign w_ovf_nxt  = r_ovf_work | w_adj[c_bcd_w-1];
    assign w_last     = (r_cnt == c_cnt_one);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_shift;
                    w_accept    = 1'b1;
                end
            end
            c_st_shift: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (start) begin
                    w_state_nxt = c_st_shift;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign ready = (r_state == c_st_idle) || (r_state == c_st_done);
    assign done  = (r_state == c_st_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_mag      <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_neg_work <= 1'b0;
            r_ovf_work <= 1'b0;
            bcd        <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mag      <= w_in_mag;
                r_neg_work <= w_in_neg;
                r_work     <= '0;
                r_ovf_work <= 1'b0;
                r_cnt      <= c_cnt_ld;
            end else if (r_state == c_st_shift) begin
                r_work     <= w_work_nxt;
                r_mag      <= {r_mag[BIN_W-2:0], 1'b0};
                r_cnt      <= r_cnt - c_cnt_one;
                r_ovf_work <= w_ovf_nxt;
                // Publish on the edge that enters DONE, using the final step.
                if (w_last) begin
                    bcd <= w_work_nxt;
                    neg <= r_neg_work;
                    ovf <= w_ovf_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bin2bcd
// Purpose  : Self-checking bench for seq_bin2bcd. It drives one operand
//            stream into a 5-digit and a 4-digit instance and compares both
//            every cycle against an arithmetic reference model. It also pins
//            selected results to hand-computed literals.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_bin2bcd;

    localparam int BIN_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              signed_mode;
    logic [BIN_W-1:0]  bin;

    logic              ready5, done5, neg5, ovf5;
    logic [19:0]       bcd5;
    logic              ready4, done4, neg4, ovf4;
    logic [15:0]       bcd4;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    seq_bin2bcd #(.BIN_W(BIN_W), .DIGITS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .bin(bin), .ready(ready5), .done(done5), .bcd(bcd5), .neg(neg5),
        .ovf(ovf5)
    );

    seq_bin2bcd #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .bin(bin), .ready(ready4), .done(done4), .bcd(bcd4), .neg(neg4),
        .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference conversion by plain integer arithmetic.
    function automatic void model_conv(input logic [BIN_W-1:0] b,
                                       input bit sm, input int dig,
                                       output logic [39:0] r_bcd,
                                       output bit r_neg, output bit r_ovf);
        longint mag;
        longint lim;
        r_neg = sm && b[BIN_W-1];
        mag   = r_neg ? ((longint'(1) << BIN_W) - longint'(b)) : longint'(b);
        lim   = 1;
        for (int i = 0; i < dig; i++) lim = lim * 10;
        r_ovf = (mag >= lim);
        r_bcd = '0;
        for (int i = 0; i < dig; i++) begin
            r_bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
    endfunction

    // Behavioural model: a busy countdown of BIN_W cycles after acceptance,
    // then a one-cycle done with the precomputed results.
    int          m_busy = 0;
    bit          m_done = 1'b0;
    bit [19:0]   m5_bcd = '0;
    bit [15:0]   m4_bcd = '0;
    bit          m_neg = 1'b0, m5_ovf = 1'b0, m4_ovf = 1'b0;
    bit [19:0]   p5_bcd = '0;
    bit [15:0]   p4_bcd = '0;
    bit          p_neg = 1'b0, p5_ovf = 1'b0, p4_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [39:0] t5, t4;
        bit tn, to5, to4;
        if (!rst_n) begin
            m_busy <= 0;
            m_done <= 1'b0;
            m5_bcd <= '0;
            m4_bcd <= '0;
            m_neg  <= 1'b0;
            m5_ovf <= 1'b0;
            m4_ovf <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy == 0 && start) begin
                model_conv(bin, signed_mode, 5, t5, tn, to5);
                model_conv(bin, signed_mode, 4, t4, tn, to4);
                p5_bcd <= t5[19:0];
                p4_bcd <= t4[15:0];
                p_neg  <= tn;
                p5_ovf <= to5;
                p4_ovf <= to4;
                m_busy <= BIN_W;
            end else if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_done <= 1'b1;
                    m5_bcd <= p5_bcd;
                    m4_bcd <= p4_bcd;
                    m_neg  <= p_neg;
                    m5_ovf <= p5_ovf;
                    m4_ovf <= p4_ovf;
                end
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready5", ready5, m_busy == 0);
            chk("done5",  done5,  m_done);
            chk("neg5",   neg5,   m_neg);
            chk("ovf5",   ovf5,   m5_ovf);
            if (!m5_ovf) chk("bcd5", bcd5, m5_bcd);
            chk("ready4", ready4, m_busy == 0);
            chk("done4",  done4,  m_done);
            chk("neg4",   neg4,   m_neg);
            chk("ovf4",   ovf4,   m4_ovf);
            if (!m4_ovf) chk("bcd4", bcd4, m4_bcd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done5) break;
        end
        if (!done5) begin
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", lat);
        end
    endtask

    task automatic conv(input logic [BIN_W-1:0] b, input bit sm,
                        output int lat);
        start       = 1'b1;
        bin         = b;
        signed_mode = sm;
        tick();
        start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int ndone;
        start       = 1'b0;
        signed_mode = 1'b0;
        bin         = '0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #1 cmp_en   = 1'b1;

        chk("rst_ready", ready5, 1'b1);
        chk("rst_done",  done5,  1'b0);
        chk("rst_bcd",   bcd5,   20'h0);
        chk("rst_ovf4",  ovf4,   1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Zero, first start after reset, latency of BIN_W cycles.
        conv(16'h0000, 1'b0, lat);
        chk("lat_zero", lat, 16);
        chk("lit_zero_bcd", bcd5, 20'h00000);
        chk("lit_zero_neg", neg5, 1'b0);

        conv(16'hFFFF, 1'b0, lat);
        chk("lit_ffff_bcd", bcd5, 20'h65535);
        chk("lit_ffff_ovf4", ovf4, 1'b1);

        conv(16'hFFFF, 1'b1, lat);
        chk("lit_m1_bcd", bcd5, 20'h00001);
        chk("lit_m1_neg", neg5, 1'b1);

        conv(16'h8000, 1'b1, lat);
        chk("lit_min_bcd", bcd5, 20'h32768);
        chk("lit_min_neg", neg5, 1'b1);
        chk("lit_min_ovf", ovf5, 1'b0);

        conv(16'd12345, 1'b0, lat);
        chk("lit_12345_ovf4", ovf4, 1'b1);
        chk("lit_12345_bcd5", bcd5, 20'h12345);

        conv(16'd9999, 1'b0, lat);
        chk("lit_9999_ovf4", ovf4, 1'b0);
        chk("lit_9999_bcd4", bcd4, 16'h9999);

        conv(16'h0000, 1'b1, lat);
        chk("lit_szero_neg", neg5, 1'b0);

        conv(16'd9, 1'b0, lat);
        conv(16'd10, 1'b0, lat);
        chk("lit_10_bcd", bcd5, 20'h00010);

        // Start during SHIFT is ignored; a start in DONE is taken directly.
        start = 1'b1; bin = 16'd100; signed_mode = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; bin = 16'd200;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("lit_100_bcd", bcd5, 20'h00100);
        start = 1'b1; bin = 16'd200;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("b2b_lat", lat, 16);
        chk("lit_200_bcd", bcd5, 20'h00200);

        // Non-zero held result so the reset clearing is visible.
        conv(16'hFFF6, 1'b1, lat);
        chk("lit_m10_bcd", bcd5, 20'h00010);
        chk("lit_m10_neg", neg5, 1'b1);

        // Reset in the eighth SHIFT cycle aborts the conversion.
        start = 1'b1; bin = 16'd777;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_bcd",   bcd5,   20'h0);
        chk("abort_neg",   neg5,   1'b0);
        chk("abort_ready", ready5, 1'b1);
        chk("abort_done",  done5,  1'b0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done5) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        conv(16'd42, 1'b0, lat);
        chk("lit_42_bcd", bcd5, 20'h00042);
        chk("lat_42", lat, 16);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
